// File: rtl/mem_bus_ctrl_pkg.sv
// Shared types and constants for the CPU-side memory bus controller.
package mem_bus_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSramRd,
    StSramWr,
    StWrRecover,
    StIoReq,
    StDone
  } state_e;

  localparam logic [7:0] IoPageDefault = 8'hFF;
  localparam int unsigned CntWidth = 8;

endpackage

// File: rtl/mem_bus_ctrl_wait_counter.sv
// Loadable down-counter with terminal-count flag; shared by SRAM wait states and I/O timeout.
module bus_wait_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             tc_o
);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/mem_bus_ctrl.sv
// CPU memory bus controller: routes accesses to async SRAM (wait states) or an I/O page
// (ready handshake with timeout) and returns data with a one-cycle ack.
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [7:0]  IO_PAGE     = IoPageDefault,
  parameter int unsigned IO_TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_address,
  input  logic [15:0] cpu_wdata,
  input  logic        cpu_read_en,
  input  logic        cpu_write_en,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_busy,
  output logic        bus_error,
  output logic [15:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic [7:0]  io_addr,
  output logic [15:0] io_wdata,
  input  logic [15:0] io_rdata,
  output logic        io_rd,
  output logic        io_wr,
  input  logic        io_ready
);

  state_e        state_q;
  logic          req_prev_q;
  logic          wr_q;
  logic [15:0]   rdata_q;
  logic          ack_q, busy_q, bus_error_q;
  logic [15:0]   sram_addr_q, sram_dq_out_q;
  logic          ce_n_q, oe_n_q, we_n_q;
  logic [7:0]    io_addr_q;
  logic [15:0]   io_wdata_q;
  logic          io_rd_q, io_wr_q;

  logic                req;
  logic                is_io;
  logic                cnt_load;
  logic [CntWidth-1:0] cnt_load_val;
  logic                cnt_tc;

  // Only a rising edge of the combined enables starts an access.
  assign req          = (cpu_read_en | cpu_write_en) & ~req_prev_q;
  assign is_io        = (cpu_address[15:8] == IO_PAGE);
  assign cnt_load     = (state_q == StIdle) && req;
  assign cnt_load_val = is_io ? CntWidth'(IO_TIMEOUT - 1) : CntWidth'(WAIT_CYCLES);

  bus_wait_counter #(
    .Width (CntWidth)
  ) u_wait_counter (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .tc_o       (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      req_prev_q    <= 1'b0;
      wr_q          <= 1'b0;
      rdata_q       <= '0;
      ack_q         <= 1'b0;
      busy_q        <= 1'b0;
      bus_error_q   <= 1'b0;
      sram_addr_q   <= '0;
      sram_dq_out_q <= '0;
      ce_n_q        <= 1'b1;
      oe_n_q        <= 1'b1;
      we_n_q        <= 1'b1;
      io_addr_q     <= '0;
      io_wdata_q    <= '0;
      io_rd_q       <= 1'b0;
      io_wr_q       <= 1'b0;
    end else begin
      req_prev_q  <= cpu_read_en | cpu_write_en;
      ack_q       <= 1'b0;
      bus_error_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req) begin
            wr_q   <= cpu_write_en;
            busy_q <= 1'b1;
            if (is_io) begin
              io_addr_q  <= cpu_address[7:0];
              io_wdata_q <= cpu_wdata;
              io_rd_q    <= ~cpu_write_en;
              io_wr_q    <= cpu_write_en;
              state_q    <= StIoReq;
            end else begin
              sram_addr_q <= cpu_address;
              ce_n_q      <= 1'b0;
              if (cpu_write_en) begin
                sram_dq_out_q <= cpu_wdata;
                we_n_q        <= 1'b0;
                state_q       <= StSramWr;
              end else begin
                oe_n_q  <= 1'b0;
                state_q <= StSramRd;
              end
            end
          end
        end
        StSramRd: begin
          if (cnt_tc) begin
            rdata_q <= sram_dq_in;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            ack_q   <= 1'b1;
            state_q <= StDone;
          end
        end
        StSramWr: begin
          if (cnt_tc) begin
            we_n_q  <= 1'b1;
            state_q <= StWrRecover;
          end
        end
        StWrRecover: begin
          ce_n_q  <= 1'b1;
          ack_q   <= 1'b1;
          state_q <= StDone;
        end
        StIoReq: begin
          // A ready arriving on the timeout cycle still wins.
          if (io_ready) begin
            if (!wr_q) rdata_q <= io_rdata;
            io_rd_q <= 1'b0;
            io_wr_q <= 1'b0;
            ack_q   <= 1'b1;
            state_q <= StDone;
          end else if (cnt_tc) begin
            if (!wr_q) rdata_q <= 16'hFFFF;
            io_rd_q     <= 1'b0;
            io_wr_q     <= 1'b0;
            ack_q       <= 1'b1;
            bus_error_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cpu_rdata   = rdata_q;
  assign cpu_ack     = ack_q;
  assign cpu_busy    = busy_q;
  assign bus_error   = bus_error_q;
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = sram_dq_out_q;
  assign sram_ce_n   = ce_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_we_n   = we_n_q;
  assign io_addr     = io_addr_q;
  assign io_wdata    = io_wdata_q;
  assign io_rd       = io_rd_q;
  assign io_wr       = io_wr_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl with behavioural SRAM and I/O device models.
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cpu_address = '0;
  logic [15:0] cpu_wdata = '0;
  logic        cpu_read_en = 1'b0;
  logic        cpu_write_en = 1'b0;
  logic [15:0] cpu_rdata;
  logic        cpu_ack, cpu_busy, bus_error;
  logic [15:0] sram_addr, sram_dq_out, sram_dq_in;
  logic        sram_ce_n, sram_oe_n, sram_we_n;
  logic [7:0]  io_addr;
  logic [15:0] io_wdata, io_rdata;
  logic        io_rd, io_wr;
  logic        io_ready = 1'b0;

  always #5 clk = ~clk;

  mem_bus_ctrl #(
    .WAIT_CYCLES (1),
    .IO_PAGE     (8'hFF),
    .IO_TIMEOUT  (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_address  (cpu_address),
    .cpu_wdata    (cpu_wdata),
    .cpu_read_en  (cpu_read_en),
    .cpu_write_en (cpu_write_en),
    .cpu_rdata    (cpu_rdata),
    .cpu_ack      (cpu_ack),
    .cpu_busy     (cpu_busy),
    .bus_error    (bus_error),
    .sram_addr    (sram_addr),
    .sram_dq_out  (sram_dq_out),
    .sram_dq_in   (sram_dq_in),
    .sram_ce_n    (sram_ce_n),
    .sram_oe_n    (sram_oe_n),
    .sram_we_n    (sram_we_n),
    .io_addr      (io_addr),
    .io_wdata     (io_wdata),
    .io_rdata     (io_rdata),
    .io_rd        (io_rd),
    .io_wr        (io_wr),
    .io_ready     (io_ready)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [15:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  // SRAM model: unwritten locations return a fixed pattern, 0x0100 holds 0xBEEF.
  logic [15:0] sram_mem [65536];
  bit          sram_written [65536];

  function automatic logic [15:0] sram_default(input logic [15:0] a);
    return (a == 16'h0100) ? 16'hBEEF : (a ^ 16'h5A5A);
  endfunction

  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n) begin
      sram_mem[sram_addr]     <= sram_dq_out;
      sram_written[sram_addr] <= 1'b1;
    end
  end

  assign sram_dq_in = sram_oe_n ? 16'h0000 :
                      (sram_written[sram_addr] ? sram_mem[sram_addr] : sram_default(sram_addr));

  // I/O model: ready during strobe cycle io_delay+1; io_delay < 0 means never.
  int          io_delay = -1;
  logic [15:0] io_val = '0;
  int          io_cyc = 0;
  assign io_rdata = io_val;

  always @(negedge clk) begin
    if (io_rd || io_wr) begin
      io_cyc   = io_cyc + 1;
      io_ready = (io_delay >= 0) && (io_cyc == io_delay + 1);
    end else begin
      io_cyc   = 0;
      io_ready = 1'b0;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          ack_cnt = 0, ack_cyc = 0, err_cnt = 0;
  int          oe_low = 0, we_low = 0, rec_cnt = 0, io_rd_cnt = 0, io_wr_cnt = 0;
  logic [15:0] rec_data = '0;
  logic [7:0]  io_addr_seen = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (!sram_oe_n) oe_low++;
      if (!sram_we_n) we_low++;
      if (!sram_ce_n && sram_we_n && sram_oe_n) begin
        rec_cnt++;
        rec_data = sram_dq_out;
      end
      if (io_rd) begin
        io_rd_cnt++;
        io_addr_seen = io_addr;
      end
      if (io_wr) io_wr_cnt++;
      if (bus_error) begin
        err_cnt++;
        check_eq("err_with_ack", {31'd0, cpu_ack}, 32'd1);
      end
      if (cpu_ack) begin
        exp_t e;
        ack_cnt++;
        ack_cyc = cyc;
        check_eq("sb_nonempty", {31'd0, (sb_q.size() > 0)}, 32'd1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check_eq("rdata", {16'd0, cpu_rdata}, {16'd0, e.rdata});
          check_eq("bus_error", {31'd0, bus_error}, {31'd0, e.err});
        end
      end
    end
  end

  task automatic access(input bit wr, input bit both, input logic [15:0] addr,
                        input logic [15:0] wdata, input int hold,
                        input logic [15:0] exp_rdata, input logic exp_err, input int exp_lat);
    int c0, a0;
    bit got;
    @(negedge clk);
    cpu_address  = addr;
    cpu_wdata    = wdata;
    cpu_write_en = wr;
    cpu_read_en  = !wr || both;
    sb_q.push_back(exp_t'{rdata: exp_rdata, err: exp_err});
    a0 = ack_cnt;
    @(posedge clk);
    #1 c0 = cyc;
    check_eq("busy", {31'd0, cpu_busy}, 32'd1);
    got = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (i >= hold) begin
        cpu_read_en  = 1'b0;
        cpu_write_en = 1'b0;
      end
      if (!got && ack_cnt != a0) begin
        got = 1'b1;
        check_eq("latency", ack_cyc - c0 + 1, exp_lat);
      end
      if (got && i >= hold) break;
    end
    check_eq("ack_seen", {31'd0, got}, 32'd1);
    cpu_read_en  = 1'b0;
    cpu_write_en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  int s0, s1, s2;

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_ce_n", {31'd0, sram_ce_n}, 32'd1);
    check_eq("rst_oe_n", {31'd0, sram_oe_n}, 32'd1);
    check_eq("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    check_eq("rst_io", {30'd0, io_rd, io_wr}, 32'd0);
    check_eq("rst_flags", {29'd0, cpu_ack, cpu_busy, bus_error}, 32'd0);
    check_eq("rst_rdata", {16'd0, cpu_rdata}, 32'd0);
    check_eq("rst_sram_addr", {16'd0, sram_addr}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // SRAM read
    s0 = oe_low;
    access(1'b0, 1'b0, 16'h0100, 16'h0000, 1, 16'hBEEF, 1'b0, 3);
    check_eq("rd_oe_cycles", oe_low - s0, 2);

    // SRAM write with recovery cycle
    s0 = we_low; s1 = rec_cnt;
    access(1'b1, 1'b0, 16'h0200, 16'h1234, 1, 16'hBEEF, 1'b0, 4);
    check_eq("wr_we_cycles", we_low - s0, 2);
    check_eq("wr_recover_cycles", rec_cnt - s1, 1);
    check_eq("wr_recover_data", {16'd0, rec_data}, 32'h1234);
    check_eq("wr_mem", {16'd0, sram_mem[16'h0200]}, 32'h1234);

    // I/O read, ready on 4th strobe cycle
    io_delay = 3; io_val = 16'h00A5;
    s0 = io_rd_cnt; s1 = err_cnt;
    access(1'b0, 1'b0, 16'hFF10, 16'h0000, 1, 16'h00A5, 1'b0, 5);
    check_eq("io_rd_cycles", io_rd_cnt - s0, 4);
    check_eq("io_addr", {24'd0, io_addr_seen}, 32'h10);
    check_eq("io_rd_no_err", err_cnt - s1, 0);

    // I/O write timeout
    io_delay = -1;
    s0 = io_wr_cnt; s1 = err_cnt;
    access(1'b1, 1'b0, 16'hFF20, 16'hCAFE, 1, 16'h00A5, 1'b1, 17);
    check_eq("io_wr_cycles", io_wr_cnt - s0, 16);
    check_eq("io_wr_err", err_cnt - s1, 1);

    // I/O read timeout returns all-ones
    access(1'b0, 1'b0, 16'hFF30, 16'h0000, 1, 16'hFFFF, 1'b1, 17);

    // Held read enable starts exactly one access
    s0 = ack_cnt;
    access(1'b0, 1'b0, 16'h0100, 16'h0000, 10, 16'hBEEF, 1'b0, 3);
    repeat (5) @(negedge clk);
    check_eq("held_one_ack", ack_cnt - s0, 1);

    // Both enables together: write
    s0 = we_low;
    access(1'b1, 1'b1, 16'h0300, 16'h5555, 1, 16'hBEEF, 1'b0, 4);
    check_eq("both_we_cycles", we_low - s0, 2);
    check_eq("both_mem", {16'd0, sram_mem[16'h0300]}, 32'h5555);

    // Reset during SRAM write
    s2 = ack_cnt;
    @(negedge clk);
    cpu_address = 16'h0400; cpu_wdata = 16'h7777; cpu_write_en = 1'b1;
    @(posedge clk);
    #1 check_eq("rst_mid_busy", {31'd0, cpu_busy}, 32'd1);
    @(negedge clk);
    cpu_write_en = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_mid_we_n", {31'd0, sram_we_n}, 32'd1);
    check_eq("rst_mid_ce_n", {31'd0, sram_ce_n}, 32'd1);
    check_eq("rst_mid_busy_low", {31'd0, cpu_busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("rst_mid_no_ack", ack_cnt - s2, 0);
    access(1'b0, 1'b0, 16'h0100, 16'h0000, 1, 16'hBEEF, 1'b0, 3);

    check_eq("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
